datapath_p: RTL and testbench
=============================

# datapath_p

Parametrised second-generation datapath: a register file, operand registers A/B, a barrel-free 1-bit shifter, an ALU with status flags, and result register C. It generalises the 16-bit/8-register datapath in data width and register count, widens the flags to Z/N/V, and adds a multi-cycle shift-add multiply with a busy/done handshake. It sits between the instruction-decode FSM, which drives all control inputs, and memory, which supplies `mdata` and consumes `datapath_out`.

## Interface
- `WIDTH`, 16: data width in bits, must be ≥ 4.
- `NREGS`, 8: register-file depth, a power of two ≥ 2; `RW = $clog2(NREGS)`.
- `PCW`, 8: PC width, must be ≤ `WIDTH`.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `readnum`, `writenum` in `RW`: register-file read and write addresses.
- `write` in 1: register-file write enable.
- `vsel` in 2: write-back data select.
  - 00 = C
  - 01 = zero-extended `pc`
  - 10 = `sximm8`
  - 11 = `mdata`
- `loada`, `loadb`, `loadc`, `loads` in 1: load enables for A, B, C and the status register.
- `asel` in 1: 1 forces the ALU A operand to zero.
- `bsel` in 1: 1 selects `sximm5` as the ALU B operand, 0 selects the shifter output.
- `shift` in 2: shifter control.
  - 00 = pass
  - 01 = left 1
  - 10 = logical right 1
  - 11 = arithmetic right 1
- `ALUop` in 3: ALU operation.
  - 000 = ADD
  - 001 = SUB
  - 010 = AND
  - 011 = NOT B
  - 100 = MUL
  - 101–111 = reserved; behave as ADD.
- `sximm5`, `sximm8`, `mdata` in `WIDTH`: immediate and memory data.
- `pc` in `PCW`: program counter.
- `datapath_out` out `WIDTH`: register C.
- `Z_out` out 3: status register. Bit 0 = Z, bit 1 = N, bit 2 = V.
- `busy` out 1: a multiply is in progress.
- `done` out 1: one-cycle pulse when a multiply completes.

## Operation
- Register file: `NREGS` × `WIDTH`. Write is synchronous when `write`=1. Read is combinational. A read of the address being written returns the old value.
- Register-file writes are accepted at all times, including while `busy`.
- Ain = `asel` ? 0 : A. Bin = `bsel` ? `sximm5` : shift(B).
- Arithmetic is modulo 2^`WIDTH`.
- Flags computed from the ALU result:
  - Z = result is 0.
  - N = result MSB.
  - V for ADD: operands have the same sign and the result sign differs.
  - V for SUB: operands have different signs and the result sign differs from Ain.
  - V for MUL: the upper `WIDTH` bits of the unsigned 2·`WIDTH` product are nonzero.
  - V for AND and NOT: 0.
- Single-cycle ops: `loadc` captures the result into C; `loads` captures the flags.
- MUL (unsigned, shift-add):
  - Start condition: `loadc`=1 and `ALUop`=100 while idle.
  - On start, capture Ain, Bin and the value of `loads`. C is not written at the start edge.
  - Two-state FSM: IDLE → MUL on start. MUL performs one partial-product step per cycle for `WIDTH` cycles, then returns to IDLE.
  - At completion: C ← low `WIDTH` bits of the product. If the captured `loads` was 1, the status register ← {V, N, Z} of the product.
- While `busy`: `loada`, `loadb`, `loadc`, `loads` are ignored. The A/B/C/status registers hold, and `datapath_out` holds its pre-multiply value.
- Reset at any time:
  - Register file, A, B, C and status all become 0.
  - FSM goes to IDLE; `busy`=0, `done`=0.
  - An in-flight multiply is aborted with no write-back.

## Timing
- Reset values: `datapath_out`=0, `Z_out`=000, `busy`=0, `done`=0, all registers 0.
- Single-cycle path: an A or B load at edge k; a C/flag load at edge k+1 earliest; `datapath_out` is valid after edge k+1.
- MUL:
  - Start edge E0. `busy`=1 from after E0 until after EW.
  - Edges E1..EW iterate.
  - At EW: C and flags update, `busy`→0, `done`→1.
  - `done` returns to 0 at EW+1.
  - Total latency: `WIDTH` cycles after the start edge.
- A new MUL start is legal at EW+1 earliest. `loadc` at edge EW itself is ignored.
- Simultaneous `write` to register r and `loada`/`loadb` reading r at the same edge: A/B receive the old value of r.

## Test plan
- Reset mid-run:
  - Load R0..R7 with distinct values, then assert `reset` asynchronously between clock edges.
  - Required: all outputs 0 immediately; a read of R3 afterwards returns 0.
- ADD overflow:
  - Steps: R0=16'h7FFF, R1=16'h0001; A←R0, B←R1; ADD with `loadc`=`loads`=1.
  - Required: `datapath_out`=16'h8000, `Z_out`=3'b110 (V=1, N=1, Z=0).
- SUB zero with right shift:
  - Steps: A=16'h0004, B=16'h0008, `shift`=10; SUB.
  - Required: result 0, `Z_out`=3'b001.
- MUL latency and handshake:
  - Steps: A=16'd300, B=16'd7, `loads`=1, start.
  - Required: `busy` high exactly 16 cycles; `done` a single 1-cycle pulse; C=16'd2100 at EW; `Z_out`=000.
  - Also: `loadc` asserted during `busy` leaves C unchanged.
- MUL overflow, then reset during a later multiply:
  - Steps: 16'h0100 × 16'h0100.
  - Required: C=0, `Z_out`=3'b101.
  - Then start another MUL and assert `reset` on cycle 5: required `busy`=0, `done` never pulses, C=0.
- Parameter sweep:
  - Configuration: `WIDTH`=8, `NREGS`=4.
  - Required: 8'd15 × 8'd17 gives C=8'hFF, `busy` for 8 cycles; write/read of R3 round-trips correctly.

Source files
------------

// File: rtl/datapath_p.sv
// datapath_p: parametrised datapath with a register file, A/B operand registers,
// a 1-bit shifter, an ALU with Z/N/V status, result register C, and a
// multi-cycle shift-add multiply with a busy/done handshake.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   readnum, writenum    register-file read/write addresses
//   write, vsel          register-file write enable and write-back select
//   loada/b/c/s          load enables for A, B, C and status
//   asel, bsel, shift    ALU operand selects and shifter control
//   ALUop                ALU operation (100 = multi-cycle MUL)
//   sximm5, sximm8       immediate operands
//   mdata, pc            memory data and program counter
//   datapath_out, Z_out  register C and status {V,N,Z}
//   busy, done           multiply in progress / one-cycle completion pulse
module datapath_p #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PCW   = 8,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RW-1:0]    readnum,
    input  logic [RW-1:0]    writenum,
    input  logic             write,
    input  logic [1:0]       vsel,
    input  logic             loada,
    input  logic             loadb,
    input  logic             loadc,
    input  logic             loads,
    input  logic             asel,
    input  logic             bsel,
    input  logic [1:0]       shift,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] sximm5,
    input  logic [WIDTH-1:0] sximm8,
    input  logic [WIDTH-1:0] mdata,
    input  logic [PCW-1:0]   pc,
    output logic [WIDTH-1:0] datapath_out,
    output logic [2:0]       Z_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int M  = WIDTH - 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    logic [WIDTH-1:0]   rf_q [NREGS];
    logic [WIDTH-1:0]   a_q, b_q, c_q;
    logic [2:0]         st_q;
    state_t             state_q;
    logic               busy_q, done_q, mls_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] mcand_q, prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q;

    logic [WIDTH-1:0] rdata, wdata, shout, ain, bin, alu_d;
    logic             v_d, is_mul, start;
    logic [2:0]       flags_d, mflags_d;

    assign rdata = rf_q[readnum];

    always_comb begin
        unique case (vsel)
            2'b00:   wdata = c_q;
            2'b01:   wdata = WIDTH'(pc);
            2'b10:   wdata = sximm8;
            default: wdata = mdata;
        endcase
    end

    always_comb begin
        unique case (shift)
            2'b00:   shout = b_q;
            2'b01:   shout = {b_q[M-1:0], 1'b0};
            2'b10:   shout = {1'b0, b_q[M:1]};
            default: shout = {b_q[M], b_q[M:1]};
        endcase
    end

    assign ain = asel ? '0 : a_q;
    assign bin = bsel ? sximm5 : shout;

    always_comb begin
        alu_d = ain + bin;
        v_d   = ~(ain[M] ^ bin[M]) & (alu_d[M] ^ ain[M]);
        case (ALUop)
            3'b001: begin
                alu_d = ain - bin;
                v_d   = (ain[M] ^ bin[M]) & (alu_d[M] ^ ain[M]);
            end
            3'b010: begin
                alu_d = ain & bin;
                v_d   = 1'b0;
            end
            3'b011: begin
                alu_d = ~bin;
                v_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign flags_d = {v_d, alu_d[M], alu_d == '0};

    // One partial-product step; the final step's sum is the full product.
    assign prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign mflags_d = {|prod_d[2*WIDTH-1:WIDTH], prod_d[M],
                       prod_d[M:0] == '0};

    assign is_mul = (ALUop == 3'b100);
    assign start  = !busy_q && loadc && is_mul;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (write) begin
            rf_q[writenum] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            st_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mls_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (loada) a_q <= rdata;
                    if (loadb) b_q <= rdata;
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, ain};
                        mplier_q <= bin;
                        prod_q   <= '0;
                        mls_q    <= loads;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_MUL;
                    end else begin
                        if (loadc) c_q <= alu_d;
                        // Status from a multiply only comes at completion.
                        if (loads && !is_mul) st_q <= flags_d;
                    end
                end
                S_MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        c_q     <= prod_d[M:0];
                        if (mls_q) st_q <= mflags_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign datapath_out = c_q;
    assign Z_out        = st_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_datapath_p.sv
// tb_datapath_p: directed and randomized checks of datapath_p against a
// behavioural model, plus a small WIDTH=8/NREGS=4 instance.
module tb_datapath_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  readnum, writenum, ALUop;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift;
    logic [15:0] sximm5, sximm8, mdata, dout;
    logic [7:0]  pc;
    logic [2:0]  zout;
    logic        busy, done;

    logic        s_reset;
    logic [1:0]  s_readnum, s_writenum;
    logic [2:0]  s_ALUop;
    logic        s_write, s_loada, s_loadb, s_loadc, s_loads, s_asel, s_bsel;
    logic [1:0]  s_vsel, s_shift;
    logic [7:0]  s_sximm5, s_sximm8, s_mdata, s_dout, s_pc;
    logic [2:0]  s_zout;
    logic        s_busy, s_done;

    datapath_p dut (
        .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8),
        .mdata(mdata), .pc(pc), .datapath_out(dout), .Z_out(zout),
        .busy(busy), .done(done)
    );

    datapath_p #(.WIDTH(8), .NREGS(4), .PCW(8)) sdut (
        .clk(clk), .reset(s_reset), .readnum(s_readnum),
        .writenum(s_writenum), .write(s_write), .vsel(s_vsel),
        .loada(s_loada), .loadb(s_loadb), .loadc(s_loadc),
        .loads(s_loads), .asel(s_asel), .bsel(s_bsel), .shift(s_shift),
        .ALUop(s_ALUop), .sximm5(s_sximm5), .sximm8(s_sximm8),
        .mdata(s_mdata), .pc(s_pc), .datapath_out(s_dout),
        .Z_out(s_zout), .busy(s_busy), .done(s_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the 16-bit / 8-register instance.
    logic [15:0] m_rf [8];
    logic [15:0] m_a, m_b, m_c;
    logic [2:0]  m_st;
    bit          m_busy, m_done, m_ls;
    int          m_left;
    logic [31:0] m_prod;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_a = '0; m_b = '0; m_c = '0; m_st = '0;
        m_busy = 0; m_done = 0; m_ls = 0; m_left = 0; m_prod = '0;
    endtask

    function automatic logic [15:0] shf(logic [15:0] b, logic [1:0] s);
        logic [15:0] r;
        case (s)
            2'd0: r = b;
            2'd1: r = b << 1;
            2'd2: r = b >> 1;
            default: r = $signed(b) >>> 1;
        endcase
        return r;
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic model_next();
        logic [15:0] rd, wd, ain, bin, res;
        int sa, sb, sr;
        bit v;
        if (reset) begin
            model_reset();
            return;
        end
        rd = m_rf[readnum];
        case (vsel)
            2'd0: wd = m_c;
            2'd1: wd = {8'h00, pc};
            2'd2: wd = sximm8;
            default: wd = mdata;
        endcase
        m_done = 0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_c = m_prod[15:0];
                if (m_ls)
                    m_st = {m_prod >= 32'h10000, m_prod[15], m_prod[15:0] == 0};
                m_busy = 0;
                m_done = 1;
            end
        end else begin
            ain = asel ? 16'h0 : m_a;
            bin = bsel ? sximm5 : shf(m_b, shift);
            sa = int'($signed(ain));
            sb = int'($signed(bin));
            if (ALUop == 3'd4 && loadc) begin
                m_prod = 32'(ain) * 32'(bin);
                m_ls = loads;
                m_busy = 1;
                m_left = 16;
            end else begin
                v = 0;
                case (ALUop)
                    3'd1: begin
                        sr = sa - sb;
                        res = ain - bin;
                        v = (sr > 32767) || (sr < -32768);
                    end
                    3'd2: res = ain & bin;
                    3'd3: res = ~bin;
                    default: begin
                        sr = sa + sb;
                        res = ain + bin;
                        v = (sr > 32767) || (sr < -32768);
                    end
                endcase
                if (loadc) m_c = res;
                if (loads && ALUop != 3'd4) m_st = {v, res[15], res == 0};
            end
            if (loada) m_a = rd;
            if (loadb) m_b = rd;
        end
        if (write) m_rf[writenum] = wd;
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("dout", dout, m_c);
            chk("zout", zout, m_st);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
        end
    end

    task automatic tick();
        model_next();
        @(posedge clk);
        #4;
    endtask

    task automatic idle();
        write = 0; loada = 0; loadb = 0; loadc = 0; loads = 0;
        asel = 0; bsel = 0; shift = 0; ALUop = 0; vsel = 0;
        readnum = 0; writenum = 0;
        s_write = 0; s_loada = 0; s_loadb = 0; s_loadc = 0; s_loads = 0;
        s_asel = 0; s_bsel = 0; s_shift = 0; s_ALUop = 0; s_vsel = 0;
        s_readnum = 0; s_writenum = 0;
    endtask

    task automatic wr(logic [2:0] r, logic [15:0] d);
        idle();
        write = 1; writenum = r; vsel = 2'd3; mdata = d;
        tick();
        idle();
    endtask

    task automatic ldab(logic [2:0] ra, logic [2:0] rb);
        idle(); loada = 1; readnum = ra; tick();
        idle(); loadb = 1; readnum = rb; tick();
        idle();
    endtask

    int bc, dc;
    bit found;

    initial begin
        reset = 1; s_reset = 1;
        sximm5 = 0; sximm8 = 0; mdata = 0; pc = 0;
        s_sximm5 = 0; s_sximm8 = 0; s_mdata = 0; s_pc = 0;
        idle();
        model_reset();
        chk_en = 1;
        tick(); tick();
        reset = 0; s_reset = 0;
        tick();
        chk("rst_dout", dout, 16'h0);
        chk("rst_zout", zout, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);

        // Reset mid-run.
        for (int i = 0; i < 8; i++) begin
            idle();
            write = 1; writenum = 3'(i); vsel = 2'd2;
            sximm8 = 16'h1111 * 16'(i + 1);
            tick();
        end
        idle();
        ldab(3, 5);
        loadc = 1; tick(); idle();
        #2;
        reset = 1;
        model_reset();
        #1;
        chk("midrst_dout", dout, 16'h0);
        chk("midrst_zout", zout, 3'b000);
        chk("midrst_busy", busy, 1'b0);
        tick();
        reset = 0;
        tick();
        loada = 1; readnum = 3; tick(); idle();
        bsel = 1; sximm5 = 16'd5; loadc = 1; tick(); idle();
        chk("r3_after_reset", dout, 16'd5);

        // ADD overflow.
        wr(0, 16'h7FFF); wr(1, 16'h0001);
        ldab(0, 1);
        loadc = 1; loads = 1; ALUop = 3'd0; tick(); idle();
        chk("add_ovf_dout", dout, 16'h8000);
        chk("add_ovf_z", zout, 3'b110);

        // SUB to zero with logical right shift of B.
        wr(2, 16'h0004); wr(3, 16'h0008);
        ldab(2, 3);
        shift = 2'b10; ALUop = 3'd1; loadc = 1; loads = 1; tick(); idle();
        chk("sub_zero_dout", dout, 16'h0);
        chk("sub_zero_z", zout, 3'b001);

        // MUL latency, handshake and ignored loads while busy.
        wr(4, 16'd300); wr(5, 16'd7);
        ldab(4, 5);
        ALUop = 3'd4; loadc = 1; loads = 1; tick(); idle();
        bc = 0; dc = 0;
        for (int k = 0; k < 24; k++) begin
            if (busy) bc++;
            if (done) begin
                dc++;
                chk("mul_c", dout, 16'd2100);
                chk("mul_z", zout, 3'b000);
            end
            if (k == 5) chk("mul_hold_c", dout, 16'h0000);
            idle();
            if (k < 16) begin
                loadc = 1; loads = 1; loada = 1; readnum = 0;
            end
            tick();
        end
        idle();
        chk("mul_busy_cycles", bc, 16);
        chk("mul_done_pulses", dc, 1);

        // MUL overflow.
        wr(6, 16'h0100); wr(7, 16'h0100);
        ldab(6, 7);
        ALUop = 3'd4; loadc = 1; loads = 1; tick(); idle();
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (done) begin
                found = 1;
                chk("mul_ovf_c", dout, 16'h0);
                chk("mul_ovf_z", zout, 3'b101);
            end else begin
                tick();
            end
        end
        chk("mul_ovf_seen", found, 1'b1);

        // Reset during a later multiply.
        wr(0, 16'd9); ldab(0, 0);
        ALUop = 3'd4; loadc = 1; loads = 1; tick(); idle();
        repeat (4) tick();
        #2;
        reset = 1;
        model_reset();
        #1;
        chk("mulrst_busy", busy, 1'b0);
        chk("mulrst_done", done, 1'b0);
        chk("mulrst_c", dout, 16'h0);
        tick();
        reset = 0;
        dc = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) dc++;
            tick();
        end
        chk("mulrst_no_done", dc, 0);

        // WIDTH=8, NREGS=4 instance.
        idle();
        s_write = 1; s_writenum = 2'd3; s_vsel = 2'd2; s_sximm8 = 8'hA5; tick();
        idle(); s_loadb = 1; s_readnum = 2'd3; tick();
        idle(); s_asel = 1; s_loadc = 1; tick();
        chk("s_r3_roundtrip", s_dout, 8'hA5);
        idle(); s_write = 1; s_writenum = 2'd0; s_vsel = 2'd2; s_sximm8 = 8'd15; tick();
        idle(); s_loada = 1; s_readnum = 2'd0; tick();
        idle(); s_bsel = 1; s_sximm5 = 8'd17; s_ALUop = 3'd4;
        s_loadc = 1; s_loads = 1; tick();
        idle();
        bc = 0; dc = 0;
        for (int k = 0; k < 14; k++) begin
            if (s_busy) bc++;
            if (s_done) begin
                dc++;
                chk("s_mul_c", s_dout, 8'hFF);
                chk("s_mul_z", s_zout, 3'b010);
            end
            tick();
        end
        chk("s_mul_busy_cycles", bc, 8);
        chk("s_mul_done_pulses", dc, 1);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            idle();
            write    = 1'($urandom);
            writenum = 3'($urandom);
            readnum  = 3'($urandom);
            vsel     = 2'($urandom);
            loada    = 1'($urandom);
            loadb    = 1'($urandom);
            loadc    = 1'($urandom);
            loads    = 1'($urandom);
            asel     = ($urandom_range(0, 3) == 0);
            bsel     = 1'($urandom);
            shift    = 2'($urandom);
            ALUop    = 3'($urandom);
            if (ALUop == 3'd4 && !loadc) loads = 0;
            sximm5   = 16'($urandom);
            sximm8   = 16'($urandom);
            mdata    = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            pc       = 8'($urandom);
            tick();
        end
        idle();
        tick();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
